addr_cmd_delay_ctrl: RTL and testbench

- Fabric-side sequencer directly upstream of the DDR3 address/command lane controller.
- Converts tap-move and tap-load commands into its delay-line control pins: DELAY_LINE_SEL, DELAY_LINE_LOAD, DELAY_LINE_DIRECTION, DELAY_LINE_MOVE.
- Brackets every update with HS_IO_CLK_PAUSE, so the high-speed lane clock is quiesced while the TX delay line changes.
- Tracks the absolute tap position and reports out-of-range.

---
 rtl/ddr_phy_ctrl_pkg.sv | 24 ++
 rtl/addr_cmd_delay_timer.sv | 31 +++
 rtl/addr_cmd_delay_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_addr_cmd_delay_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ddr_phy_ctrl_pkg.sv
// Shared definitions for the DDR3 PHY fabric-side controllers.
//   ctrl_state_e : sequencer states for the delay-line command FSM
//   OP_MOVE/LOAD : command opcodes (2'b1x is reserved)
//   tap_at_limit : true when a one-tap step in 'dir' would leave 0..max_pos
package ddr_phy_ctrl_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StGap,
    StHold,
    StDone
  } ctrl_state_e;

  localparam logic [1:0] OP_MOVE = 2'b00;
  localparam logic [1:0] OP_LOAD = 2'b01;

  function automatic logic tap_at_limit(input logic [7:0] pos, input logic dir,
                                        input logic [7:0] max_pos);
    return dir ? (pos >= max_pos) : (pos == 8'd0);
  endfunction

endpackage

// File: rtl/addr_cmd_delay_timer.sv
// Loadable down-counter with a zero flag, shared by the SETUP, GAP and HOLD phases.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   load_i     : load load_val_i this cycle (wins over counting)
//   load_val_i : value to load; phase length minus one
//   zero_o     : counter is zero, i.e. the current cycle is the last of the phase
module addr_cmd_delay_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             zero_o
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      count_q <= '0;
    end else if (load_i) begin
      count_q <= load_val_i;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/addr_cmd_delay_ctrl.sv
// Fabric-side sequencer for the DDR3 address/command lane TX delay line.
// Turns tap-move / tap-load commands into DELAY_LINE_* pulses, bracketing each
// update with HS_IO_CLK_PAUSE, and tracks the absolute tap position.
//   FAB_CLK, RESET           : clock, synchronous active-high reset
//   CMD_VALID/READY          : command handshake (READY only in idle)
//   CMD_OP, CMD_DIR, CMD_TAPS: opcode, direction (1 = more delay), tap count
//   DONE                     : one-cycle completion pulse
//   STATUS_OOR               : sticky out-of-range flag for the last command
//   TAP_POS                  : tracked tap position, clamped to 0..TAP_MAX
//   TX_DELAY_LINE_OUT_OF_RANGE : lane out-of-range flag, sampled in the last GAP cycle
//   DELAY_LINE_*, HS_IO_CLK_PAUSE : registered controls to the lane
module addr_cmd_delay_ctrl
  import ddr_phy_ctrl_pkg::*;
#(
  parameter int unsigned PAUSE_SETUP = 4,
  parameter int unsigned PAUSE_HOLD  = 4,
  parameter int unsigned MOVE_GAP    = 2,
  parameter int unsigned TAP_MAX     = 127,
  parameter int unsigned LOAD_VAL    = 1
) (
  input  logic       FAB_CLK,
  input  logic       RESET,
  input  logic       CMD_VALID,
  output logic       CMD_READY,
  input  logic [1:0] CMD_OP,
  input  logic       CMD_DIR,
  input  logic [7:0] CMD_TAPS,
  output logic       DONE,
  output logic       STATUS_OOR,
  output logic [7:0] TAP_POS,
  input  logic       TX_DELAY_LINE_OUT_OF_RANGE,
  output logic       DELAY_LINE_SEL,
  output logic       DELAY_LINE_LOAD,
  output logic       DELAY_LINE_DIRECTION,
  output logic       DELAY_LINE_MOVE,
  output logic       HS_IO_CLK_PAUSE
);

  // Timer loads are phase length minus one: zero flags the final cycle.
  localparam logic [7:0] SETUP_LD = 8'(PAUSE_SETUP - 1);
  localparam logic [7:0] GAP_LD   = 8'(MOVE_GAP - 1);
  localparam logic [7:0] HOLD_LD  = 8'(PAUSE_HOLD - 1);
  localparam logic [7:0] TAP_MAX8 = 8'(TAP_MAX);
  localparam logic [7:0] LOAD_V8  = 8'(LOAD_VAL);

  ctrl_state_e state_q, state_nx;

  logic [1:0] op_q;
  logic       dir_q;
  logic [7:0] rem_q;
  logic [7:0] tap_q;
  logic       ready_q, done_q, oor_q, pause_q, move_q, load_q;

  logic       accept;
  logic       is_load;
  logic       at_limit;
  logic       timer_load;
  logic [7:0] timer_val;
  logic       timer_zero;

  assign accept   = (state_q == StIdle) && CMD_VALID;
  assign is_load  = (op_q == OP_LOAD);
  assign at_limit = tap_at_limit(tap_q, dir_q, TAP_MAX8);

  addr_cmd_delay_timer #(
    .WIDTH (8)
  ) u_timer (
    .clk_i      (FAB_CLK),
    .rst_i      (RESET),
    .load_i     (timer_load),
    .load_val_i (timer_val),
    .zero_o     (timer_zero)
  );

  // Next state and timer loads for the phase being entered.
  always_comb begin
    state_nx   = state_q;
    timer_load = 1'b0;
    timer_val  = '0;
    unique case (state_q)
      StIdle: begin
        if (CMD_VALID) begin
          // Reserved opcodes and zero-tap moves complete without touching the lane.
          if (CMD_OP[1] || ((CMD_OP == OP_MOVE) && (CMD_TAPS == 8'd0))) begin
            state_nx = StDone;
          end else begin
            state_nx   = StSetup;
            timer_load = 1'b1;
            timer_val  = SETUP_LD;
          end
        end
      end
      StSetup: begin
        if (timer_zero) state_nx = StPulse;
      end
      StPulse: begin
        if (!is_load && at_limit) begin
          state_nx   = StHold;
          timer_load = 1'b1;
          timer_val  = HOLD_LD;
        end else begin
          state_nx   = StGap;
          timer_load = 1'b1;
          timer_val  = GAP_LD;
        end
      end
      StGap: begin
        if (timer_zero) begin
          // rem_q already reflects the pulse just issued.
          if (TX_DELAY_LINE_OUT_OF_RANGE || (rem_q == 8'd0)) begin
            state_nx   = StHold;
            timer_load = 1'b1;
            timer_val  = HOLD_LD;
          end else begin
            state_nx = StPulse;
          end
        end
      end
      StHold: begin
        if (timer_zero) state_nx = StDone;
      end
      StDone: begin
        state_nx = StIdle;
      end
      default: begin
        state_nx = StIdle;
      end
    endcase
  end

  always_ff @(posedge FAB_CLK) begin
    if (RESET) begin
      state_q <= StIdle;
      op_q    <= OP_MOVE;
      dir_q   <= 1'b0;
      rem_q   <= '0;
      tap_q   <= LOAD_V8;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      oor_q   <= 1'b0;
      pause_q <= 1'b0;
      move_q  <= 1'b0;
      load_q  <= 1'b0;
    end else begin
      state_q <= state_nx;
      ready_q <= (state_nx == StIdle);
      done_q  <= (state_nx == StDone);
      pause_q <= (state_nx inside {StSetup, StPulse, StGap});
      // PULSE is only entered from SETUP/GAP, where tap_q is already settled,
      // so the saturation decision can be registered on entry.
      move_q  <= (state_nx == StPulse) && !is_load && !at_limit;
      load_q  <= (state_nx == StPulse) && is_load;

      if (accept) begin
        op_q  <= CMD_OP;
        dir_q <= CMD_DIR;
        rem_q <= (CMD_OP == OP_MOVE) ? CMD_TAPS : 8'd0;
        oor_q <= 1'b0;
      end else if (state_nx == StIdle) begin
        dir_q <= 1'b0;
      end

      if (state_q == StPulse) begin
        if (is_load) begin
          tap_q <= LOAD_V8;
        end else if (at_limit) begin
          oor_q <= 1'b1;
        end else begin
          tap_q <= dir_q ? (tap_q + 8'd1) : (tap_q - 8'd1);
          rem_q <= rem_q - 8'd1;
        end
      end

      if ((state_q == StGap) && timer_zero && TX_DELAY_LINE_OUT_OF_RANGE) begin
        oor_q <= 1'b1;
      end
    end
  end

  assign CMD_READY            = ready_q;
  assign DONE                 = done_q;
  assign STATUS_OOR           = oor_q;
  assign TAP_POS              = tap_q;
  assign DELAY_LINE_SEL       = pause_q;
  assign HS_IO_CLK_PAUSE      = pause_q;
  assign DELAY_LINE_MOVE      = move_q;
  assign DELAY_LINE_LOAD      = load_q;
  assign DELAY_LINE_DIRECTION = dir_q;

endmodule

// File: tb/tb_addr_cmd_delay_ctrl.sv
module tb_addr_cmd_delay_ctrl;

  localparam int PAUSE_SETUP = 4;
  localparam int PAUSE_HOLD  = 4;
  localparam int MOVE_GAP    = 2;
  localparam int TAP_MAX     = 127;
  localparam int LOAD_VAL    = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_op = 2'b00;
  logic       cmd_dir = 1'b0;
  logic [7:0] cmd_taps = 8'd0;
  logic       tx_oor = 1'b0;
  logic       cmd_ready, done, status_oor;
  logic [7:0] tap_pos;
  logic       dl_sel, dl_load, dl_dir, dl_move, clk_pause;

  int checks = 0;
  int fails  = 0;
  int model_tap = LOAD_VAL;

  typedef struct {
    int lat;
    int tap;
    int oor;
    int moves;
    int loads;
    int pause;
    int first;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  addr_cmd_delay_ctrl #(
    .PAUSE_SETUP (PAUSE_SETUP),
    .PAUSE_HOLD  (PAUSE_HOLD),
    .MOVE_GAP    (MOVE_GAP),
    .TAP_MAX     (TAP_MAX),
    .LOAD_VAL    (LOAD_VAL)
  ) dut (
    .FAB_CLK                    (clk),
    .RESET                      (rst),
    .CMD_VALID                  (cmd_valid),
    .CMD_READY                  (cmd_ready),
    .CMD_OP                     (cmd_op),
    .CMD_DIR                    (cmd_dir),
    .CMD_TAPS                   (cmd_taps),
    .DONE                       (done),
    .STATUS_OOR                 (status_oor),
    .TAP_POS                    (tap_pos),
    .TX_DELAY_LINE_OUT_OF_RANGE (tx_oor),
    .DELAY_LINE_SEL             (dl_sel),
    .DELAY_LINE_LOAD            (dl_load),
    .DELAY_LINE_DIRECTION       (dl_dir),
    .DELAY_LINE_MOVE            (dl_move),
    .HS_IO_CLK_PAUSE            (clk_pause)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // Cycle-level model: cycle 0 is the acceptance edge; lane OOR is driven high
  // for cycles lo..hi and only matters in the last GAP cycle.
  function automatic exp_t model(input int op, input int dir, input int taps, input int start,
                                 input int lo, input int hi);
    exp_t e;
    int   t;
    int   pos;
    int   hold_start;
    bit   stop;
    e.tap = start; e.oor = 0; e.moves = 0; e.loads = 0; e.first = -1;
    if (op >= 2 || (op == 0 && taps == 0)) begin
      e.lat = 1; e.pause = 0;
      return e;
    end
    t = 1 + PAUSE_SETUP;
    pos = start;
    hold_start = t;
    if (op == 1) begin
      e.loads = 1; e.first = t; pos = LOAD_VAL;
      if (t + MOVE_GAP >= lo && t + MOVE_GAP <= hi) e.oor = 1;
      hold_start = t + 1 + MOVE_GAP;
    end else begin
      stop = 0;
      for (int i = 0; i < taps && !stop; i++) begin
        if ((dir != 0 && pos >= TAP_MAX) || (dir == 0 && pos == 0)) begin
          e.oor = 1; hold_start = t + 1; stop = 1;
        end else begin
          e.moves++;
          if (e.first < 0) e.first = t;
          pos += (dir != 0) ? 1 : -1;
          hold_start = t + 1 + MOVE_GAP;
          if (t + MOVE_GAP >= lo && t + MOVE_GAP <= hi) begin
            e.oor = 1; stop = 1;
          end
          t += 1 + MOVE_GAP;
        end
      end
    end
    e.tap = pos;
    e.pause = hold_start - 1;
    e.lat = hold_start + PAUSE_HOLD;
    return e;
  endfunction

  task automatic wait_ready(input string tag);
    int n = 0;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_ready"}, cmd_ready, 1);
  endtask

  task automatic run_cmd(input string tag, input int op, input int dir, input int taps,
                         input int lo, input int hi);
    exp_t e;
    int   done_k = -1, moves = 0, loads = 0, pauses = 0, sels = 0, first = -1, busy_rdy = 0;
    sb.push_back(model(op, dir, taps, model_tap, lo, hi));
    wait_ready(tag);
    cmd_valid = 1'b1;
    cmd_op    = 2'(op);
    cmd_dir   = 1'(dir);
    cmd_taps  = 8'(taps);
    for (int k = 1; k < 3000; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      tx_oor = (k >= lo && k <= hi);
      if (k == 1) check({tag, "_dir"}, dl_dir, 32'(dir));
      if (dl_move) moves++;
      if (dl_load) loads++;
      if (clk_pause) pauses++;
      if (dl_sel) sels++;
      if ((dl_move || dl_load) && first < 0) first = k;
      if (done) begin
        done_k = k;
        break;
      end
      if (cmd_ready) busy_rdy++;
    end
    tx_oor = 1'b0;
    e = sb.pop_front();
    check({tag, "_done_cycle"}, 32'(done_k), 32'(e.lat));
    check({tag, "_tap"}, 32'(tap_pos), 32'(e.tap));
    check({tag, "_oor"}, 32'(status_oor), 32'(e.oor));
    check({tag, "_moves"}, 32'(moves), 32'(e.moves));
    check({tag, "_loads"}, 32'(loads), 32'(e.loads));
    check({tag, "_pause_cycles"}, 32'(pauses), 32'(e.pause));
    check({tag, "_sel_cycles"}, 32'(sels), 32'(e.pause));
    check({tag, "_first_pulse"}, 32'(first), 32'(e.first));
    check({tag, "_ready_busy"}, 32'(busy_rdy), 0);
    @(negedge clk);
    check({tag, "_done_1cyc"}, done, 0);
    check({tag, "_ready_after"}, cmd_ready, 1);
    check({tag, "_dir_idle"}, dl_dir, 0);
    model_tap = e.tap;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int ndone;
    int done_k;
    int loads;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_ready", cmd_ready, 1);
    check("rst_done", done, 0);
    check("rst_oor", status_oor, 0);
    check("rst_tap", 32'(tap_pos), LOAD_VAL);
    check("rst_ctrl", {dl_sel, dl_load, dl_dir, dl_move, clk_pause}, 0);
    rst = 1'b0;

    // MOVE up 3 from 1; lane OOR in a non-final GAP cycle is ignored
    run_cmd("move_up3", 0, 1, 3, 6, 6);
    // Reserved opcode behaves as a zero-tap MOVE
    run_cmd("reserved_op", 2, 1, 5, 0, -1);
    // Climb to 40, then LOAD back to LOAD_VAL
    run_cmd("move_up36", 0, 1, 36, 0, -1);
    run_cmd("load", 1, 0, 9, 0, -1);
    // 1 -> 2, then down 5 saturates at 0
    run_cmd("move_up1", 0, 1, 1, 0, -1);
    run_cmd("move_dn5_sat", 0, 0, 5, 0, -1);
    // Lane OOR during second GAP aborts after 2 pulses
    run_cmd("move_up4_abort", 0, 1, 4, 9, 10);

    // RESET at cycle 9 of a MOVE of 10
    wait_ready("rst_mid");
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dir = 1'b1; cmd_taps = 8'd10;
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
    end
    check("rst_mid_pause_before", clk_pause, 1);
    rst = 1'b1;
    @(negedge clk);
    check("rst_mid_pause", clk_pause, 0);
    check("rst_mid_move", dl_move, 0);
    check("rst_mid_tap", 32'(tap_pos), LOAD_VAL);
    check("rst_mid_ready", cmd_ready, 1);
    check("rst_mid_done", done, 0);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    check("rst_mid_no_done", 32'(ndone), 0);
    model_tap = LOAD_VAL;

    // Zero-tap MOVE with CMD_VALID held high, then a LOAD accepted right after DONE
    wait_ready("zero_tap");
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_dir = 1'b0; cmd_taps = 8'd0;
    @(negedge clk);
    check("zero_done_c1", done, 1);
    check("zero_pause_c1", clk_pause, 0);
    check("zero_ready_c1", cmd_ready, 0);
    cmd_op = 2'b01;
    @(negedge clk);
    check("zero_ready_c2", cmd_ready, 1);
    check("zero_done_c2", done, 0);
    done_k = -1;
    loads = 0;
    for (int k = 3; k < 60; k++) begin
      @(negedge clk);
      if (dl_load) loads++;
      if (done) begin
        done_k = k;
        cmd_valid = 1'b0;
        break;
      end
    end
    cmd_valid = 1'b0;
    check("b2b_load_done_cycle", 32'(done_k), 2 + 1 + PAUSE_SETUP + 1 + MOVE_GAP + PAUSE_HOLD);
    check("b2b_loads", 32'(loads), 1);
    check("b2b_tap", 32'(tap_pos), LOAD_VAL);
    @(negedge clk);
    check("b2b_done_1cyc", done, 0);
    check("b2b_ready_after", cmd_ready, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
